z16_fetch_ctrl: RTL and testbench

Instruction fetch sequencer for the Z16 core.
- Owns the fetch PC and drives the byte address into the combinational instruction memory.
- Buffers returned instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports branch/jump redirect (with flush) and a halt request that stops fetching while the buffer drains.

---
 rtl/z16_fetch_ctrl.sv | 96 +++++++++
 tb/tb_z16_fetch_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/z16_fetch_ctrl.sv
// Z16 instruction fetch sequencer: owns the fetch PC, buffers fetched words in a
// small FIFO for decode, and handles redirect/flush and halt-with-drain.
module z16_fetch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          DEPTH    = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [15:0] o_mem_addr,
  input  logic [15:0] i_mem_instr,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [15:0] o_instr,
  output logic [15:0] o_pc,
  input  logic        i_redirect,
  input  logic [15:0] i_redirect_pc,
  input  logic        i_halt,
  output logic        o_halted
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {S_RUN, S_HALT} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_pc;
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic [15:0]     r_buf_pc    [DEPTH];
  logic [15:0]     r_buf_instr [DEPTH];

  logic            w_valid;
  logic            w_pop;
  logic            w_push;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & i_ready;
  // A pop in the same cycle frees a slot, so a full buffer still sustains 1/cycle.
  assign w_push  = (r_state == S_RUN) & ~i_halt & ~i_redirect &
                   ((r_count < DEPTH_C) | w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:   if (i_halt)  w_state_nxt = S_HALT;
      S_HALT:  if (!i_halt) w_state_nxt = S_RUN;
      default: w_state_nxt = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc    <= {RESET_PC[15:1], 1'b0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_redirect) begin
      r_pc    <= {i_redirect_pc[15:1], 1'b0};
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc   <= r_pc + 16'd2;
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Buffer storage carries no reset; occupancy is tracked by r_count alone.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf_pc[r_tail]    <= r_pc;
      r_buf_instr[r_tail] <= i_mem_instr;
    end
  end

  assign o_mem_addr = r_pc;
  assign o_valid    = w_valid;
  assign o_instr    = w_valid ? r_buf_instr[r_head] : 16'h0000;
  assign o_pc       = w_valid ? r_buf_pc[r_head]    : 16'h0000;
  assign o_halted   = (r_state == S_HALT) & (r_count == '0);

endmodule

// File: tb/tb_z16_fetch_ctrl.sv
// Bench for z16_fetch_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_z16_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_addr;
  logic [15:0] mem_instr;
  logic        valid;
  logic        ready;
  logic [15:0] instr;
  logic [15:0] pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic [15:0] mq[$];
  logic [15:0] m_pc;
  bit          m_halt;
  bit          m_known = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a ^ 16'h1357) + {a[7:0], a[15:8]};
  endfunction

  assign mem_instr = mem_word(mem_addr);

  z16_fetch_ctrl #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .o_mem_addr   (mem_addr),
    .i_mem_instr  (mem_instr),
    .o_valid      (valid),
    .i_ready      (ready),
    .o_instr      (instr),
    .o_pc         (pc),
    .i_redirect   (redirect),
    .i_redirect_pc(redirect_pc),
    .i_halt       (halt),
    .o_halted     (halted)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model, advance the model with the current inputs,
  // then move past the next rising edge.
  task automatic step();
    bit pop, push;
    if (m_known) begin
      chk("m_valid",  {15'd0, valid},  {15'd0, mq.size() != 0});
      chk("m_instr",  instr,  (mq.size() != 0) ? mem_word(mq[0]) : 16'h0000);
      chk("m_pc",     pc,     (mq.size() != 0) ? mq[0] : 16'h0000);
      chk("m_addr",   mem_addr, m_pc);
      chk("m_halted", {15'd0, halted}, {15'd0, m_halt && mq.size() == 0});
    end
    if (rst) begin
      mq.delete();
      m_pc    = 16'h0000;
      m_halt  = 0;
      m_known = 1;
    end else if (m_known) begin
      pop  = (mq.size() != 0) && ready;
      push = !m_halt && !halt && !redirect && (mq.size() < 2 || pop);
      if (pop) void'(mq.pop_front());
      if (redirect) begin
        mq.delete();
        m_pc = redirect_pc & 16'hFFFE;
      end else if (push) begin
        mq.push_back(m_pc);
        m_pc = m_pc + 16'd2;
      end
      m_halt = halt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int hs;
    rst = 1'b1; ready = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000; halt = 1'b0;
    @(posedge clk); #1;

    // 1: streaming from reset
    do_reset();
    ready = 1'b1;
    chk("t1_first_invalid", {15'd0, valid}, 16'd0);
    step();
    chk("t1_valid", {15'd0, valid}, 16'd1);
    chk("t1_pc0", pc, 16'h0000);
    chk("t1_instr0", instr, mem_word(16'h0000));
    step(); chk("t1_pc2", pc, 16'h0002);
    step(); chk("t1_pc4", pc, 16'h0004);

    // 2: backpressure then release
    do_reset();
    ready = 1'b0;
    repeat (5) step();
    chk("t2_addr_hold", mem_addr, 16'h0004);
    chk("t2_head", pc, 16'h0000);
    ready = 1'b1;
    chk("t2_seq0", pc, 16'h0000); step();
    chk("t2_seq1", pc, 16'h0002); step();
    chk("t2_seq2", pc, 16'h0004); step();
    chk("t2_seq3", pc, 16'h0006);

    // 3: redirect with full buffer
    ready = 1'b0;
    step(); step();
    redirect = 1'b1; redirect_pc = 16'h0019;
    step();
    redirect = 1'b0;
    chk("t3_flush_valid", {15'd0, valid}, 16'd0);
    chk("t3_addr", mem_addr, 16'h0018);
    step();
    chk("t3_valid", {15'd0, valid}, 16'd1);
    chk("t3_pc", pc, 16'h0018);

    // 4: halt with drain
    step();
    ready = 1'b1; halt = 1'b1;
    hs = 0;
    for (int i = 0; i < 4; i++) begin
      if (valid && ready) hs++;
      step();
    end
    chk("t4_handshakes", 16'(hs), 16'd2);
    chk("t4_valid", {15'd0, valid}, 16'd0);
    chk("t4_halted", {15'd0, halted}, 16'd1);
    chk("t4_addr_frozen", mem_addr, 16'h001C);
    halt = 1'b0;
    step();
    chk("t4_unhalted", {15'd0, halted}, 16'd0);
    step();
    chk("t4_resume_pc", pc, 16'h001C);

    // 5: wrap at top of address space
    redirect = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect = 1'b0;
    step(); chk("t5_pc_fffe", pc, 16'hFFFE);
    step(); chk("t5_pc_0000", pc, 16'h0000);
    step(); chk("t5_pc_0002", pc, 16'h0002);

    // 6: reset while halted with a full buffer
    ready = 1'b0;
    step(); step();
    halt = 1'b1;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; halt = 1'b0;
    chk("t6_valid", {15'd0, valid}, 16'd0);
    chk("t6_halted", {15'd0, halted}, 16'd0);
    chk("t6_addr", mem_addr, 16'h0000);
    ready = 1'b1;
    step();
    chk("t6_pc0", pc, 16'h0000);
    step();
    chk("t6_pc2", pc, 16'h0002);

    // Mixed traffic against the model
    for (int i = 0; i < 300; i++) begin
      ready       = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 11) == 0);
      redirect_pc = 16'($urandom);
      if ($urandom_range(0, 9) == 0) halt = ~halt;
      rst         = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0; redirect = 1'b0; halt = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
